pll_hdmi_cfg: RTL and testbench

PLL_HDMI_CFG -- requirements
Module: pll_hdmi_cfg

---
 rtl/pll_hdmi_cfg_pkg.sv | 33 +++
 rtl/pll_hdmi_cfg_if.sv | 21 ++
 rtl/pll_hdmi_cfg_rom.sv | 60 ++++++
 rtl/pll_hdmi_cfg.sv | 132 +++++++++++++
 tb/tb_pll_hdmi_cfg.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pll_hdmi_cfg_pkg.sv
// Shared constants, types and helpers for the HDMI PLL reconfiguration sequencer.
package pll_hdmi_cfg_pkg;

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C     = 6'd5;
  localparam logic [5:0] ADDR_K     = 6'd7;
  localparam logic [5:0] ADDR_BW    = 6'd8;
  localparam logic [5:0] ADDR_CP    = 6'd9;

  // Wide enough for the longest sequence (18 counters -> 25 words).
  localparam int IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_GUARD,
    ST_WAITLOCK
  } state_e;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } word_t;

  function automatic int word_count(input int ncnt);
    return 7 + ncnt;
  endfunction

endpackage

// File: rtl/pll_hdmi_cfg_if.sv
// Reconfiguration management bus between the sequencer (master) and the PLL reconfig block (slave).
interface pll_hdmi_cfg_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_write,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_write,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_hdmi_cfg_rom.sv
// Preset table of {address, data} words; registered read, output held while rd_en is low.
module pll_hdmi_cfg_rom
  import pll_hdmi_cfg_pkg::*;
#(
  parameter int NCNT = 1,
  parameter int PW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [PW-1:0]    preset,
  input  logic [IDX_W-1:0] idx,
  output logic [5:0]       addr,
  output logic [31:0]      data
);

  word_t word_q, word_d;

  // All presets share a 445.5 MHz VCO (50 MHz * 8.91); only the C post-divider changes.
  function automatic logic [31:0] c_base(input int p);
    case (p)
      1:       c_base = 32'h0000_0303;   // /6  -> 74.25 MHz
      2:       c_base = 32'h0000_0606;   // /12 -> 37.125 MHz
      3:       c_base = 32'h0002_0504;   // /9  -> 49.5 MHz, odd duty
      default: c_base = 32'h0002_0102;   // /3  -> 148.5 MHz, odd duty
    endcase
  endfunction

  function automatic word_t lookup(input int p, input int i);
    word_t      w;
    logic [4:0] csel;
    csel = '0;
    if (i == 0)              w = '{addr: ADDR_MODE, data: 32'h0000_0000};
    else if (i == 1)         w = '{addr: ADDR_N,    data: 32'h0001_0000};
    else if (i == 2)         w = '{addr: ADDR_M,    data: 32'h0000_0404};
    else if (i < 3 + NCNT) begin
      csel = 5'(i - 3);
      w    = '{addr: ADDR_C, data: c_base(p) | {9'b0, csel, 18'b0}};
    end
    else if (i == 3 + NCNT)  w = '{addr: ADDR_K,    data: 32'hE8F5_C239};
    else if (i == 4 + NCNT)  w = '{addr: ADDR_BW,   data: 32'h0000_0007};
    else if (i == 5 + NCNT)  w = '{addr: ADDR_CP,   data: 32'h0000_0001};
    else                     w = '{addr: ADDR_START, data: 32'h0000_0000};
    return w;
  endfunction

  always_comb begin
    word_d = word_q;
    if (rd_en) word_d = lookup(int'(preset), int'(idx));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign addr = word_q.addr;
  assign data = word_q.data;

endmodule

// File: rtl/pll_hdmi_cfg.sv
// Sequencer writing one preset's register words to the PLL reconfig bus, then waiting for relock.
// Optional lock timeout in WAITLOCK is enabled by defining PLLCFG_LOCK_TIMEOUT_EN.
module pll_hdmi_cfg
  import pll_hdmi_cfg_pkg::*;
#(
  parameter int  NPRESET = 4,
  parameter int  NCNT    = 1,
  parameter int  TOUT_W  = 20,
  parameter int  GUARD   = 16,
  localparam int PW      = (NPRESET > 1) ? $clog2(NPRESET) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] preset,
  input  logic          req,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          locked,
  pll_hdmi_cfg_if.master mgmt
);

  localparam int               GW       = (GUARD > 1) ? $clog2(GUARD + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(word_count(NCNT) - 1);

  state_e             state_q, state_d;
  logic [PW-1:0]      preset_q, preset_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GW-1:0]      guard_q, guard_d;
  logic [TOUT_W-1:0]  tout_q, tout_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               rom_rd;

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    idx_d    = idx_q;
    guard_d  = guard_q;
    tout_d   = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rom_rd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (int'(preset) < NPRESET) begin
            preset_d = preset;
            idx_d    = '0;
            state_d  = ST_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        rom_rd  = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Address/data come from the ROM register, which only reloads in FETCH,
        // so they stay put for the whole stall.
        if (!mgmt.mgmt_waitrequest) begin
          if (idx_q == LAST_IDX) begin
            guard_d = '0;
            state_d = ST_GUARD;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_GUARD: begin
        if (guard_q == GW'(GUARD - 1)) state_d = ST_WAITLOCK;
        else                           guard_d = guard_q + 1'b1;
      end
      ST_WAITLOCK: begin
        tout_d = tout_q + 1'b1;
        if (locked) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef PLLCFG_LOCK_TIMEOUT_EN
        else if (&tout_d) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      preset_q <= '0;
      idx_q    <= '0;
      guard_q  <= '0;
      tout_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      idx_q    <= idx_d;
      guard_q  <= guard_d;
      tout_q   <= tout_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  pll_hdmi_cfg_rom #(
    .NCNT (NCNT),
    .PW   (PW)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (rom_rd),
    .preset (preset_q),
    .idx    (idx_q),
    .addr   (mgmt.mgmt_address),
    .data   (mgmt.mgmt_writedata)
  );

  assign mgmt.mgmt_write = (state_q == ST_WRITE);
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_pll_hdmi_cfg.sv
// Directed self-checking bench for pll_hdmi_cfg (NPRESET=3 so an out-of-range preset fits the port).
module tb_pll_hdmi_cfg;

  localparam int NPRESET_T = 3;
  localparam int GUARD_T   = 16;
  localparam int TOUT_W_T  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] preset;
  logic       req;
  logic       locked;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  pll_hdmi_cfg_if mgmt_if ();

  pll_hdmi_cfg #(
    .NPRESET (NPRESET_T),
    .NCNT    (1),
    .TOUT_W  (TOUT_W_T),
    .GUARD   (GUARD_T)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .preset (preset),
    .req    (req),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .locked (locked),
    .mgmt   (mgmt_if)
  );

  always #5 clk = ~clk;

  // Log of accepted bus writes.
  logic [5:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  always @(posedge clk) begin
    if (!rst && mgmt_if.mgmt_write === 1'b1 && mgmt_if.mgmt_waitrequest === 1'b0) begin
      wq_addr.push_back(mgmt_if.mgmt_address);
      wq_data.push_back(mgmt_if.mgmt_writedata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0]  exp_a[8];
    logic [31:0] exp_d[8];
    int base, m_cycles, m_bad, busy_bad, start_c, done_c, err_c, m_writes, err_seen;

    exp_a = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd7, 6'd8, 6'd9, 6'd2};
    exp_d = '{32'h0, 32'h0001_0000, 32'h0000_0404, 32'h0002_0102,
              32'hE8F5_C239, 32'h7, 32'h1, 32'h0};

    rst = 1'b1; req = 1'b0; preset = 2'd0; locked = 1'b0;
    mgmt_if.mgmt_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);
    chk("rst_write", mgmt_if.mgmt_write, 0);
    chk("rst_addr",  mgmt_if.mgmt_address, 0);
    chk("rst_data",  mgmt_if.mgmt_writedata, 0);
    rst = 1'b0;

    // A: preset 0, M write stalled 5 cycles, locked after the start write.
    @(negedge clk);
    base = wq_addr.size();
    preset = 2'd0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    m_cycles = 0; m_bad = 0; busy_bad = 0; start_c = -1; done_c = -1;
    for (int c = 0; c < 200; c++) begin
      if (done === 1'b1) done_c = c;
      else if (busy !== 1'b1) busy_bad++;
      if (mgmt_if.mgmt_write === 1'b1 && mgmt_if.mgmt_address === 6'd4) begin
        m_cycles++;
        if (mgmt_if.mgmt_writedata !== 32'h0000_0404) m_bad++;
      end
      mgmt_if.mgmt_waitrequest = (mgmt_if.mgmt_write === 1'b1) &&
                                 (mgmt_if.mgmt_address === 6'd4) && (m_cycles <= 5);
      if (mgmt_if.mgmt_write === 1'b1 && mgmt_if.mgmt_address === 6'd2 &&
          !mgmt_if.mgmt_waitrequest) begin
        start_c = c;
        locked  = 1'b1;
      end
      if (done_c >= 0) break;
      @(negedge clk);
    end
    chk("a_done_seen", done_c >= 0, 1);
    chk("a_busy_held", busy_bad, 0);
    chk("a_busy_at_done", busy, 0);
    chk("a_m_stall_cycles", m_cycles, 6);
    chk("a_m_stall_data", m_bad, 0);
    // Acceptance edge -> GUARD cycles -> one WAITLOCK cycle -> done edge, sampled one negedge later.
    chk("a_done_latency", done_c - start_c, GUARD_T + 2);
    @(negedge clk);
    chk("a_done_pulse", done, 0);
    chk("a_write_count", wq_addr.size() - base, 8);
    m_writes = 0;
    if (wq_addr.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("a_addr%0d", i), wq_addr[base + i], exp_a[i]);
        chk($sformatf("a_data%0d", i), wq_data[base + i], exp_d[i]);
        if (wq_addr[base + i] === 6'd4) m_writes++;
      end
    end
    chk("a_m_single_write", m_writes, 1);

    // B: out-of-range preset.
    locked = 1'b0;
    base = wq_addr.size();
    preset = 2'd3; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("b_err_pulse", err, 1);
    chk("b_busy", busy, 0);
    chk("b_write", mgmt_if.mgmt_write, 0);
    @(negedge clk);
    chk("b_err_clear", err, 0);
    chk("b_busy_after", busy, 0);
    chk("b_no_writes", wq_addr.size() - base, 0);

    // C: preset 1, a second req while busy is ignored, never locks.
    base = wq_addr.size();
    preset = 2'd1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    preset = 2'd0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
`ifdef PLLCFG_LOCK_TIMEOUT_EN
    start_c = -1; err_c = -1;
    for (int c = 0; c < 300; c++) begin
      if (err === 1'b1) begin err_c = c; break; end
      if (mgmt_if.mgmt_write === 1'b1 && mgmt_if.mgmt_address === 6'd2) start_c = c;
      @(negedge clk);
    end
    chk("c_err_seen", err_c >= 0, 1);
    // GUARD cycles, 15 WAITLOCK cycles, err visible on the following negedge.
    chk("c_timeout_latency", err_c - start_c, GUARD_T + 16);
    chk("c_busy_fell", busy, 0);
`else
    busy_bad = 0; err_seen = 0;
    for (int c = 0; c < 1000; c++) begin
      if (busy !== 1'b1) busy_bad++;
      if (err !== 1'b0) err_seen++;
      @(negedge clk);
    end
    chk("c_busy_1000", busy_bad, 0);
    chk("c_no_err", err_seen, 0);
`endif
    chk("c_write_count", wq_addr.size() - base, 8);
    if (wq_addr.size() >= base + 8) begin
      chk("c_c0_addr", wq_addr[base + 3], 6'd5);
      chk("c_c0_data", wq_data[base + 3], 32'h0000_0303);
    end

    // D: reset from WAITLOCK/IDLE, then reset in the middle of the N write.
    rst = 1'b1;
    #1;
    chk("d_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    preset = 2'd0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    m_cycles = -1;
    for (int c = 0; c < 50; c++) begin
      if (mgmt_if.mgmt_write === 1'b1 && mgmt_if.mgmt_address === 6'd3) begin
        m_cycles = c;
        break;
      end
      @(negedge clk);
    end
    chk("d_n_write_seen", m_cycles >= 0, 1);
    rst = 1'b1;
    #1;
    chk("d_write_dropped", mgmt_if.mgmt_write, 0);
    chk("d_addr_cleared", mgmt_if.mgmt_address, 0);
    chk("d_data_cleared", mgmt_if.mgmt_writedata, 0);
    chk("d_busy_cleared", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    base = wq_addr.size();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (wq_addr.size() > base) break;
      @(negedge clk);
    end
    chk("d_restart_seen", wq_addr.size() > base, 1);
    if (wq_addr.size() > base) begin
      chk("d_restart_addr", wq_addr[base], 6'd0);
      chk("d_restart_data", wq_data[base], 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
